// File: rtl/cpu_memory_if.sv
// CPU memory bus and host program-load handshake.
// The memory side uses slave; the CPU/host side uses master.
interface cpu_memory_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mar;
  logic              mw;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] memory_data;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              reload;
  logic              cpu_rst;
  logic              running;
  logic [15:0]       store_count;

  modport master (
    output mar, mw, acc,
    output load_valid, load_addr,
    output load_data, load_last,
    output reload,
    input  memory_data, load_ready,
    input  cpu_rst, running,
    input  store_count
  );

  modport slave (
    input  mar, mw, acc,
    input  load_valid, load_addr,
    input  load_data, load_last,
    input  reload,
    output memory_data, load_ready,
    output cpu_rst, running,
    output store_count
  );
endinterface

// File: rtl/cpu_memory.sv
// Word memory for the CPU bus with boot sequencing:
// zero-fill, host program load, then release CPU.
module cpu_memory #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  cpu_memory_if.slave bus
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_LOAD,
    S_RUN
  } state_t;

  localparam state_t S_INIT =
    CLEAR_ON_RESET ? S_CLEAR : S_LOAD;

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [15:0]       store_count_q;
  logic              cpu_rst_q;
  logic              running_q;
  logic              load_ready_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              load_fire;

  assign load_fire = bus.load_valid && load_ready_q;

  // Boot FSM with registered handshake and CPU-reset outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      clr_addr_q    <= '0;
      store_count_q <= '0;
      cpu_rst_q     <= 1'b1;
      running_q     <= 1'b0;
      load_ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == '1) begin
            state_q      <= S_LOAD;
            load_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          load_ready_q <= 1'b1;
          if (load_fire && bus.load_last) begin
            state_q       <= S_RUN;
            load_ready_q  <= 1'b0;
            cpu_rst_q     <= 1'b0;
            running_q     <= 1'b1;
            store_count_q <= '0;
          end
        end
        S_RUN: begin
          if (bus.mw) begin
            store_count_q <= store_count_q + 16'd1;
          end
          if (bus.reload) begin
            state_q      <= S_LOAD;
            load_ready_q <= 1'b1;
            cpu_rst_q    <= 1'b1;
            running_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  // Single write port: zero-fill, host load or CPU store.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = clr_addr_q;
    wdata_d = '0;
    unique case (state_q)
      S_CLEAR: begin
        we_d = 1'b1;
      end
      S_LOAD: begin
        we_d    = load_fire;
        waddr_d = bus.load_addr;
        wdata_d = bus.load_data;
      end
      S_RUN: begin
        we_d    = bus.mw;
        waddr_d = bus.mar;
        wdata_d = bus.acc;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // Array has no reset; the zero-fill phase initialises it.
  always_ff @(posedge clk) begin
    if (we_d) begin
      mem_q[waddr_d] <= wdata_d;
    end
  end

  assign bus.memory_data =
    running_q ? mem_q[bus.mar] : '0;
  assign bus.load_ready  = load_ready_q;
  assign bus.cpu_rst     = cpu_rst_q;
  assign bus.running     = running_q;
  assign bus.store_count = store_count_q;

endmodule

// File: tb/tb_cpu_memory.sv
// Directed bench for cpu_memory: boot, load, run,
// store, reload and mid-load reset, scoreboard-checked.
module tb_cpu_memory;

  logic clk;
  logic rst_n;

  cpu_memory_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  cpu_memory #(
    .ADDR_W(8),
    .DATA_W(16),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [256];
  bit          loaded [256];
  int          ncmp;
  int          nfail;

  task automatic expect_v(input string tag,
                          input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    ncmp++;
    if (sb.size() == 0) begin
      nfail++;
      $error("FAIL sb_empty observed=%h required=none",
             obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        nfail++;
        $error("FAIL %s observed=%h required=%h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_bit(input string tag,
                         input logic obs,
                         input logic req);
    expect_v(tag, 16'(req));
    check(16'(obs));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a);
    bus.mar = a;
    #1;
    expect_v($sformatf("rd_%02h", a), model[a]);
    check(bus.memory_data);
  endtask

  task automatic load(input logic [7:0] a,
                      input logic [15:0] d,
                      input logic last);
    bus.load_valid = 1'b1;
    bus.load_addr  = a;
    bus.load_data  = d;
    bus.load_last  = last;
    model[a]       = d;
    loaded[a]      = 1'b1;
    step();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      model[i]  = 16'h0000;
      loaded[i] = 1'b0;
    end
  endtask

  task automatic run_clear(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      bus.load_valid = 1'b1;
      bus.load_addr  = (i == 0) ? 8'h00 : 8'(i - 1);
      bus.load_data  = 16'hA000 | 16'(i);
      bus.load_last  = 1'b0;
      bus.mw         = 1'b1;
      bus.mar        = (i == 0) ? 8'h00 : 8'(i - 1);
      bus.acc        = 16'h5A00 | 16'(i);
      step();
      if (i < 255) begin
        if (bus.load_ready !== 1'b0 ||
            bus.cpu_rst !== 1'b1 ||
            bus.memory_data !== 16'h0000) begin
          bad++;
        end
      end
    end
    bus.load_valid = 1'b0;
    bus.mw         = 1'b0;
    expect_v({tag, "_hold"}, 16'h0000);
    check(16'(bad));
    chk_bit({tag, "_ready"}, bus.load_ready, 1'b1);
    chk_bit({tag, "_cpu_rst"}, bus.cpu_rst, 1'b1);
  endtask

  initial begin
    ncmp           = 0;
    nfail          = 0;
    rst_n          = 1'b0;
    bus.mar        = '0;
    bus.mw         = 1'b0;
    bus.acc        = '0;
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.reload     = 1'b0;
    model_clear();

    step();
    chk_bit("rst_cpu_rst", bus.cpu_rst, 1'b1);
    chk_bit("rst_ready", bus.load_ready, 1'b0);
    chk_bit("rst_running", bus.running, 1'b0);
    expect_v("rst_mdata", 16'h0000);
    check(bus.memory_data);
    expect_v("rst_count", 16'h0000);
    check(bus.store_count);

    rst_n = 1'b1;
    run_clear("clear1");

    load(8'h00, 16'h0210, 1'b0);
    chk_bit("ld_tput0", bus.load_ready, 1'b1);
    load(8'h01, 16'h9999, 1'b0);
    chk_bit("ld_tput1", bus.load_ready, 1'b1);
    load(8'h01, 16'h0311, 1'b0);
    chk_bit("ld_tput2", bus.cpu_rst, 1'b1);
    load(8'h10, 16'h0005, 1'b1);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk_bit("run_cpu_rst", bus.cpu_rst, 1'b0);
    chk_bit("run_running", bus.running, 1'b1);
    chk_bit("run_ready", bus.load_ready, 1'b0);
    expect_v("run_count", 16'h0000);
    check(bus.store_count);

    rd(8'h10);
    rd(8'h01);
    rd(8'h00);
    for (int a = 0; a < 256; a++) begin
      if (!loaded[a]) rd(8'(a));
    end

    bus.mar        = 8'h11;
    bus.acc        = 16'hBEEF;
    bus.mw         = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_addr  = 8'h12;
    bus.load_data  = 16'h7777;
    model[8'h11]   = 16'hBEEF;
    step();
    bus.mw         = 1'b0;
    bus.load_valid = 1'b0;
    rd(8'h11);
    rd(8'h12);
    expect_v("store_count1", 16'h0001);
    check(bus.store_count);

    bus.mar      = 8'h20;
    bus.acc      = 16'h1234;
    bus.mw       = 1'b1;
    bus.reload   = 1'b1;
    model[8'h20] = 16'h1234;
    step();
    bus.mw     = 1'b0;
    bus.reload = 1'b0;
    expect_v("simul_count", 16'h0002);
    check(bus.store_count);
    chk_bit("simul_cpu_rst", bus.cpu_rst, 1'b1);
    chk_bit("simul_ready", bus.load_ready, 1'b1);
    chk_bit("simul_running", bus.running, 1'b0);
    expect_v("simul_mdata", 16'h0000);
    check(bus.memory_data);

    bus.mw  = 1'b1;
    bus.mar = 8'h21;
    bus.acc = 16'h5555;
    load(8'h30, 16'h00AA, 1'b1);
    bus.mw         = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk_bit("rerun_running", bus.running, 1'b1);
    expect_v("rerun_count", 16'h0000);
    check(bus.store_count);
    rd(8'h20);
    rd(8'h11);
    rd(8'h30);
    rd(8'h21);

    bus.mar = 8'h22;
    bus.acc = 16'h0001;
    bus.mw  = 1'b1;
    model[8'h22] = 16'h0001;
    step();
    bus.mw     = 1'b0;
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    load(8'h50, 16'h1111, 1'b0);
    load(8'h51, 16'h2222, 1'b0);
    load(8'h52, 16'h3333, 1'b0);
    bus.load_valid = 1'b0;
    expect_v("mid_count_pre", 16'h0001);
    check(bus.store_count);
    rst_n = 1'b0;
    #1;
    chk_bit("mid_cpu_rst", bus.cpu_rst, 1'b1);
    chk_bit("mid_ready", bus.load_ready, 1'b0);
    chk_bit("mid_running", bus.running, 1'b0);
    expect_v("mid_count", 16'h0000);
    check(bus.store_count);
    expect_v("mid_mdata", 16'h0000);
    check(bus.memory_data);
    step();
    rst_n = 1'b1;
    model_clear();
    run_clear("clear2");

    load(8'h60, 16'h0001, 1'b1);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk_bit("final_running", bus.running, 1'b1);
    rd(8'h50);
    rd(8'h51);
    rd(8'h52);
    rd(8'h20);
    rd(8'h11);
    rd(8'h60);

    if (sb.size() != 0) begin
      nfail++;
      $error("FAIL sb_leftover observed=%0d required=0",
             sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/cpu_memory.md
# cpu_memory

Word-addressed 256x16 memory that sits on the far side of the simple CPU's memory bus: it answers CPU reads on `memory_data` from the CPU-driven `mar`, and commits `acc` to `mem[mar]` on `mw`. It also owns boot sequencing. After reset it zero-fills the array, then accepts a program image over a host load handshake, then releases the CPU from reset. A `reload` request returns it to the load phase.

## Interface
Parameters
- `ADDR_W`, 8: address width; depth is 2**ADDR_W words.
- `DATA_W`, 16: word width.
- `CLEAR_ON_RESET`, 1: 1 = run the zero-fill phase after reset; 0 = go straight to LOAD.

Ports
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mar`  in  ADDR_W  CPU address.
- `mw`  in  1  CPU write strobe, sampled on the rising edge.
- `acc`  in  DATA_W  CPU write data.
- `memory_data`  out  DATA_W  read data. Combinational `mem[mar]` in RUN; 0 otherwise.
- `load_valid`  in  1  host word valid.
- `load_ready`  out  1  high only in LOAD.
- `load_addr`  in  ADDR_W  host target address.
- `load_data`  in  DATA_W  host word.
- `load_last`  in  1  marks the final word of the image.
- `reload`  in  1  one-cycle request: return to LOAD.
- `cpu_rst`  out  1  active-high reset to the CPU; high in every state except RUN.
- `running`  out  1  high in RUN.
- `store_count`  out  16  number of CPU writes committed since the last entry to RUN. Wraps at 16 bits.

## Operation
State machine: CLEAR -> LOAD -> RUN, and RUN -> LOAD on `reload`.

- **CLEAR**
  - Each cycle writes 0 to `mem[clr_addr]`, then `clr_addr` increments.
  - On the edge that writes address 2**ADDR_W-1, the FSM goes to LOAD.
  - CPU and host ports are ignored.
- **LOAD**
  - A host word is accepted on an edge where `load_valid && load_ready`; that edge writes `mem[load_addr] <= load_data`.
  - If the accepted word also has `load_last`, the FSM goes to RUN and `store_count` clears to 0.
  - `load_valid` with `load_ready` low has no effect. The host holds its word until accepted.
  - `mw` is ignored.
- **RUN**
  - `memory_data = mem[mar]` combinationally (asynchronous read).
  - An edge with `mw` = 1 writes `mem[mar] <= acc` and increments `store_count`.
  - An edge with `reload` = 1 goes to LOAD and raises `cpu_rst` after that edge.
  - If `mw` and `reload` are both high on the same edge, the CPU write still commits and is counted. Then the FSM goes to LOAD.
  - Host port is ignored.
- **Memory behaviour**
  - Array contents are not reset asynchronously; CLEAR initialises them.
  - With `CLEAR_ON_RESET` = 0, contents are undefined until loaded.
  - A word written in LOAD with the same address twice: the last accepted write wins.
- **Reset** (`rst_n` low, any state, including mid-CLEAR or mid-LOAD)
  - State goes to CLEAR (LOAD if `CLEAR_ON_RESET` = 0) immediately.
  - `clr_addr` = 0, `store_count` = 0.
  - `cpu_rst` = 1, `load_ready` = 0, `running` = 0, `memory_data` = 0.
  - A partial load is abandoned; the host must resend the full image.

## Timing
- **Read latency:** zero cycles. `memory_data` follows `mar` in the same cycle, and the CPU samples it on the next edge.
- **CPU write:** committed on the edge where `mw` = 1. A read of the same address in the following cycle returns the new value.
- **Host write:** one word per cycle at full throughput (`load_ready` stays high in LOAD).
- **CLEAR duration:** exactly 2**ADDR_W cycles (256 by default).
  - `load_ready` rises after the 256th rising edge with `rst_n` high.
- **LOAD to RUN:** `cpu_rst` falls and `running` rises after the edge that accepts the `load_last` word. The CPU's first fetch occurs at the earliest one cycle later.
- **Reset release:** `rst_n` deasserts asynchronously. The first rising edge with `rst_n` high performs the first CLEAR write, to address 0.

## Test plan
- **Reset and clear:**
  - Stimulus: assert `rst_n` = 0, release, count cycles.
  - Required: `cpu_rst` = 1 and `load_ready` = 0 through 256 edges, then `load_ready` = 1; after RUN, every address never loaded reads 0.
- **Load and run:**
  - Stimulus: load `{0x00: 0x0210, 0x01: 0x0311, 0x10: 0x0005}` with `load_last` on the third word.
  - Required: `cpu_rst` falls the next cycle; with `mar` = 0x10 in RUN, `memory_data` = 0x0005.
- **CPU store:**
  - Stimulus: in RUN, `mar` = 0x11, `acc` = 0xBEEF, `mw` pulsed for one cycle.
  - Required: `mem[0x11]` reads 0xBEEF the next cycle; `store_count` = 1.
- **Simultaneous store and reload:**
  - Stimulus: `mw` = 1 and `reload` = 1 on the same edge, `mar` = 0x20, `acc` = 0x1234.
  - Required: `mem[0x20]` = 0x1234, `store_count` increments, then `cpu_rst` = 1, `load_ready` = 1, `memory_data` = 0.
- **Handshake stall:**
  - Stimulus: hold `load_valid` = 1 with varying `load_addr`/`load_data` while in CLEAR.
  - Required: no array writes occur; once in LOAD, one word is accepted per cycle.
- **Reset mid-load:**
  - Stimulus: load 3 words, then pull `rst_n` low for 1 cycle.
  - Required: outputs return to reset values immediately; CLEAR reruns for 256 cycles and zeroes the loaded words.
